// File: rtl/fetch_mem_responder.sv
// rtl/fetch_mem_responder.sv - instruction store with clear sweep, loader port and fixed-latency fetch path
module fetch_mem_responder #(
  parameter int          ADDR_W       = 8,
  parameter int          READ_LATENCY = 2,
  parameter logic [15:0] INIT_WORD    = 16'h0018
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address_rom,
  output logic [15:0] q_rom,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  input  logic        load_done,
  output logic        running,
  output logic [15:0] load_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              ready_q;
  logic              running_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem [DEPTH];

  logic [15:0]       rd_word;
  logic [15:0]       pipe_q [READ_LATENCY];

  logic              unused_addr_bits;
  assign unused_addr_bits = ^{address_rom[15:ADDR_W], load_addr[15:ADDR_W]};

  always_comb begin
    state_d   = state_q;
    clr_d     = clr_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = load_addr[ADDR_W-1:0];
    mem_wdata = load_data;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_q;
        mem_wdata = INIT_WORD;
        clr_d     = clr_q + ADDR_W'(1);
        if (clr_q == '1) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // A write offered together with load_done still lands before RUN.
        if (load_valid && ready_q) begin
          mem_we = 1'b1;
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        if (load_done) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_q     <= '0;
      cnt_q     <= 16'd0;
      ready_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_q     <= clr_d;
      cnt_q     <= cnt_d;
      ready_q   <= (state_d == S_LOAD);
      running_q <= (state_d == S_RUN);
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Outside RUN the fetch unit sees only NOP, whatever the store holds.
  assign rd_word = (state_q == S_RUN) ? mem[address_rom[ADDR_W-1:0]] : INIT_WORD;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_q[i] <= INIT_WORD;
      end
    end else begin
      pipe_q[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_rom      = pipe_q[READ_LATENCY-1];
  assign load_ready = ready_q;
  assign running    = running_q;
  assign load_count = cnt_q;

endmodule

// File: tb/tb_fetch_mem_responder.sv
// tb/tb_fetch_mem_responder.sv - directed self-checking bench for fetch_mem_responder
module tb_fetch_mem_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address_rom = 16'h0000;
  logic [15:0] q_rom;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_addr = 16'h0000;
  logic [15:0] load_data = 16'h0000;
  logic        load_done = 1'b0;
  logic        running;
  logic [15:0] load_count;

  int errors = 0;
  int checks = 0;

  fetch_mem_responder dut (
    .clock      (clock),
    .reset      (reset),
    .address_rom(address_rom),
    .q_rom      (q_rom),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_done  (load_done),
    .running    (running),
    .load_count (load_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives at negedge, leaves the word on the bus across exactly one rising edge.
  task automatic write_word(input logic [15:0] a, input logic [15:0] d, input logic done);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    load_done  = done;
    @(negedge clock);
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  task automatic pulse_done();
    load_done = 1'b1;
    @(negedge clock);
    load_done = 1'b0;
  endtask

  // Issues one address per cycle and checks each word two edges later.
  task automatic read_burst(input logic [15:0] addrs [], input logic [15:0] exps [], input string tag);
    for (int i = 0; i < addrs.size() + 2; i++) begin
      if (i >= 2) check_eq($sformatf("%s[%0d]", tag, i - 2), q_rom, exps[i-2]);
      if (i < addrs.size()) address_rom = addrs[i];
      @(negedge clock);
    end
  endtask

  // Releases reset at a negedge and runs the 256-cycle clear sweep.
  task automatic release_and_clear(input string tag);
    reset = 1'b0;
    repeat (255) @(posedge clock);
    @(negedge clock);
    check_eq({tag, "_ready_255"}, {15'd0, load_ready}, 16'd0);
    check_eq({tag, "_q_clear"}, q_rom, 16'h0018);
    @(negedge clock);
    check_eq({tag, "_ready_256"}, {15'd0, load_ready}, 16'd1);
    check_eq({tag, "_count_load"}, load_count, 16'd0);
  endtask

  logic [15:0] rd_a [];
  logic [15:0] rd_e [];

  initial begin
    repeat (3) @(negedge clock);
    check_eq("rst_q", q_rom, 16'h0018);
    check_eq("rst_ready", {15'd0, load_ready}, 16'd0);
    check_eq("rst_running", {15'd0, running}, 16'd0);
    check_eq("rst_count", load_count, 16'd0);

    // Loader activity during the sweep must be ignored.
    load_valid = 1'b1;
    load_addr  = 16'h0003;
    load_data  = 16'hAAAA;
    fork
      release_and_clear("c1");
      begin
        repeat (40) @(negedge clock);
        load_valid = 1'b0;
      end
    join

    write_word(16'h0000, 16'h1234, 1'b0);
    write_word(16'h0001, 16'h5678, 1'b0);
    check_eq("count_two", load_count, 16'd2);
    write_word(16'h0105, 16'hBEEF, 1'b0);
    write_word(16'h0007, 16'h7777, 1'b1);
    check_eq("running_set", {15'd0, running}, 16'd1);
    check_eq("ready_run", {15'd0, load_ready}, 16'd0);
    check_eq("count_four", load_count, 16'd4);
    check_eq("q_pre_run", q_rom, 16'h0018);

    rd_a = '{16'h0000, 16'h0001, 16'h0002, 16'h0005, 16'h0007, 16'h0100, 16'h0003};
    rd_e = '{16'h1234, 16'h5678, 16'h0018, 16'hBEEF, 16'h7777, 16'h1234, 16'h0018};
    read_burst(rd_a, rd_e, "run_rd");

    write_word(16'h0000, 16'hFFFF, 1'b1);
    check_eq("count_hold", load_count, 16'd4);
    rd_a = '{16'h0000};
    rd_e = '{16'h1234};
    read_burst(rd_a, rd_e, "ignored_wr");
    check_eq("still_running", {15'd0, running}, 16'd1);

    reset = 1'b1;
    #1;
    check_eq("mid_rst_running", {15'd0, running}, 16'd0);
    check_eq("mid_rst_q", q_rom, 16'h0018);
    check_eq("mid_rst_count", load_count, 16'd0);
    @(negedge clock);
    release_and_clear("c2");
    pulse_done();
    check_eq("rerun_running", {15'd0, running}, 16'd1);
    rd_a = '{16'h0000, 16'h0005};
    rd_e = '{16'h0018, 16'h0018};
    read_burst(rd_a, rd_e, "rerun_rd");
    check_eq("rerun_count", load_count, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_mem_responder.md
Name: fetch_mem_responder

Overview:
Memory-side responder for the instruction-fetch interface. It answers fetch addresses on address_rom with instruction words on q_rom after a fixed, registered latency. It also provides a loader write port that fills the instruction store before execution starts. After reset it sweeps the whole store to the NOP word, accepts program words, then switches to RUN and serves fetches from the loaded contents.

Parameters:
ADDR_W, 8, store depth is 2**ADDR_W words; address_rom bits above ADDR_W are ignored, so addresses wrap.
READ_LATENCY, 2, clock edges from address_rom sampled to q_rom valid; legal range 1..4.
INIT_WORD, 16'h0018, NOP encoding written by the clear sweep and driven on q_rom outside RUN.

Ports:
clock  in  1  single clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-high reset.
address_rom  in  16  fetch address from the fetch unit.
q_rom  out  16  instruction word returned to the fetch unit.
load_valid  in  1  loader presents a word to write.
load_ready  out  1  responder accepts a loader word this cycle.
load_addr  in  16  write address; bits above ADDR_W are ignored.
load_data  in  16  write data.
load_done  in  1  single-cycle pulse that ends loading and enters RUN.
running  out  1  high while in RUN.
load_count  out  16  count of words accepted since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, removal synchronous to clock):
  - state = CLEAR, clear counter = 0.
  - q_rom and every read-pipeline stage = INIT_WORD.
  - load_ready = 0, running = 0, load_count = 0.
  - The store array itself is not reset.
- CLEAR:
  - Writes INIT_WORD to store[clear counter] each cycle and increments the counter.
  - Lasts exactly 2**ADDR_W cycles; after the write to the last address, next state is LOAD.
  - load_ready = 0; load_valid and load_done are ignored.
- LOAD:
  - load_ready = 1.
  - A write occurs on an edge where load_valid && load_ready: store[load_addr[ADDR_W-1:0]] <= load_data, and load_count increments (saturating).
  - Later writes to the same address overwrite earlier ones.
  - load_done = 1 sets next state to RUN. If load_valid is also 1 in that cycle, the write still completes first.
- RUN:
  - load_ready = 0; load_valid and load_done are ignored; load_count holds.
  - There is no path back to LOAD except reset.
- Read path:
  - Every cycle, address_rom[ADDR_W-1:0] is sampled into a READ_LATENCY-deep pipeline.
  - The word read is store[addr] when state was RUN at the sampling edge, otherwise INIT_WORD.
  - q_rom is the pipeline output. For a READ_LATENCY of 2, an address applied before edge k appears on q_rom after edge k+1.
  - One new address is accepted per cycle, at full throughput, with no stall.
  - A fetch unit that idles on NOP therefore sees only NOP until RUN and its pipeline drain.
- Reset mid-LOAD or mid-RUN: returns to CLEAR, the store is re-swept, and all loaded content is lost.
- running = (state == RUN), driven from a register.

Test Plan:
- Apply reset, hold address_rom = 0 → q_rom = 16'h0018 throughout CLEAR; load_ready rises exactly 256 cycles after reset release.
- In LOAD, write 0x0000→16'h1234 and 0x0001→16'h5678, then pulse load_done → running = 1, load_count = 2.
- In RUN, drive address_rom 0, then 1, then 2 on consecutive cycles → q_rom shows 16'h1234, 16'h5678, 16'h0018, each 2 edges after its address.
- Write 0x0105→16'hBEEF (wraps to address 5), then read address 5 in RUN → q_rom = 16'hBEEF; also check that load_valid and load_done pulsed in the same cycle both write the word and enter RUN.
- Assert reset mid-RUN, then reload nothing and pulse load_done → reading address 0 returns 16'h0018 and load_count = 0.
- In RUN, pulse load_valid with 0x0000→16'hFFFF → ignored: q_rom for address 0 still 16'h1234 and load_count unchanged.
